// File: rtl/dmem_responder.sv
// dmem_responder: data-memory target for the core's memory stage.
// Word-organised RAM with byte lanes; loads run through an IDLE/WAIT/DONE
// FSM with a down-counter for READ_LATENCY, stores commit in one cycle.
// Optional MMIO output register at 32'hFFFF_FFF0, enabled by DMEM_MMIO_EN.
//
// state  | meaning
// S_IDLE | ready; stores commit, loads are accepted and stall asserted
// S_WAIT | read in flight; latency counter runs down, stall held
// S_DONE | extended load data valid for one cycle, stall released
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_stall,
  output logic [31:0] mmio_out
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam logic [2:0]  CNT_LOAD  = 3'(READ_LATENCY - 1);
  localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        state;
  logic [2:0]    cnt;
  logic [1:0]    cap_off;
  logic [1:0]    cap_size;
  logic          cap_uns;
  logic [31:0]   rd_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   offset;
  logic [AW-1:0] word_idx;
  logic          in_ram;
  logic          misaligned;
  logic          size_bad;
  logic          mmio_page;
  logic          mmio_hit;
  logic          illegal;
  logic          accept;
  logic          legal_acc;
  logic          ram_wr;
  logic          ram_rd;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;
  logic [31:0]   ext_data;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;

  // An address below BASE_ADDR wraps to a huge offset and fails the range test.
  assign offset     = req_addr - BASE_ADDR;
  assign word_idx   = offset[AW+1:2];
  assign in_ram     = {1'b0, offset} < RAM_BYTES;
  assign misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                      ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
  assign size_bad   = (req_size == 2'd3);

`ifdef DMEM_MMIO_EN
  // The whole 0xFFFF_FFxx page belongs to MMIO; only the word at F0 is mapped.
  assign mmio_page = (req_addr[31:8] == 24'hFF_FFFF);
  assign mmio_hit  = (req_addr == MMIO_ADDR) && (req_size == 2'd2);
`else
  assign mmio_page = 1'b0;
  assign mmio_hit  = 1'b0;
`endif

  assign illegal   = size_bad | misaligned | (mmio_page & ~mmio_hit) |
                     (~in_ram & ~mmio_hit);
  assign accept    = req_valid & (state == S_IDLE) & ~rst;
  assign legal_acc = accept & ~illegal;
  assign ram_wr    = legal_acc & req_write & ~mmio_hit;
  assign ram_rd    = legal_acc & ~req_write & ~mmio_hit;

  // Byte-lane enables and lane-replicated store data from size and addr[1:0].
  always_comb begin
    be        = 4'b0000;
    wdata_rep = req_wdata;
    case (req_size)
      2'd0: begin
        be        = 4'b0001 << req_addr[1:0];
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        be        = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      2'd2: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // RAM array: byte-lane store writes, synchronous read captured at load accept.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
    if (ram_rd) rd_q <= mem[word_idx];
  end

  // Load FSM: capture request fields, count down the read latency, present data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 3'd0;
      cap_off  <= 2'd0;
      cap_size <= 2'd0;
      cap_uns  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ram_rd) begin
            cap_off  <= req_addr[1:0];
            cap_size <= req_size;
            cap_uns  <= req_unsigned;
            cnt      <= CNT_LOAD;
            state    <= (READ_LATENCY == 1) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt <= 3'd1) state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DMEM_MMIO_EN
  logic [31:0] mmio_q;
  logic        mmio_wr;
  logic        mmio_rd;

  assign mmio_wr = legal_acc & req_write & mmio_hit;
  assign mmio_rd = legal_acc & ~req_write & mmio_hit;

  // MMIO output register, written by word stores to MMIO_ADDR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mmio_q <= 32'h0;
    else if (mmio_wr) mmio_q <= req_wdata;
  end

  assign mmio_out = mmio_q;
`else
  assign mmio_out = 32'h0;
`endif

  // Select and extend the captured byte/half from the registered RAM word.
  always_comb begin
    byte_sel = rd_q[{cap_off, 3'b000} +: 8];
    half_sel = cap_off[1] ? rd_q[31:16] : rd_q[15:0];
    case (cap_size)
      2'd0:    ext_data = {{24{~cap_uns & byte_sel[7]}}, byte_sel};
      2'd1:    ext_data = {{16{~cap_uns & half_sel[15]}}, half_sel};
      default: ext_data = rd_q;
    endcase
  end

  // Response mux: data only in DONE (or a same-cycle MMIO read), zero otherwise.
  always_comb begin
    rsp_rdata = 32'h0;
    if (!rst) begin
      if (state == S_DONE) rsp_rdata = ext_data;
`ifdef DMEM_MMIO_EN
      else if (mmio_rd) rsp_rdata = mmio_q;
`endif
    end
  end

  assign rsp_err   = accept & illegal;
  assign mem_stall = ~rst & ((state == S_WAIT) | ram_rd);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance A uses READ_LATENCY=2,
// instance B uses READ_LATENCY=1 for the back-to-back pattern.
module tb_dmem_responder;

  localparam int RL_A = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_valid, a_write, a_uns;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_wdata, a_rdata, a_mmio;
  logic        a_err, a_stall;

  logic        b_valid, b_write, b_uns;
  logic [1:0]  b_size;
  logic [31:0] b_addr, b_wdata, b_rdata, b_mmio;
  logic        b_err, b_stall;

  int tests_run    = 0;
  int tests_failed = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .READ_LATENCY(RL_A), .BASE_ADDR(32'h0)) u_dut_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_write(a_write),
    .req_size(a_size), .req_unsigned(a_uns), .req_addr(a_addr),
    .req_wdata(a_wdata), .rsp_rdata(a_rdata), .rsp_err(a_err),
    .mem_stall(a_stall), .mmio_out(a_mmio)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .READ_LATENCY(1), .BASE_ADDR(32'h0)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_write(b_write),
    .req_size(b_size), .req_unsigned(b_uns), .req_addr(b_addr),
    .req_wdata(b_wdata), .rsp_rdata(b_rdata), .rsp_err(b_err),
    .mem_stall(b_stall), .mmio_out(b_mmio)
  );

  task automatic drive_a(input logic v, input logic w, input logic [1:0] sz,
                         input logic u, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    a_valid = v; a_write = w; a_size = sz; a_uns = u; a_addr = addr; a_wdata = wd;
    #1;
  endtask

  task automatic drive_b(input logic v, input logic w, input logic [31:0] addr,
                         input logic [31:0] wd);
    @(negedge clk);
    b_valid = v; b_write = w; b_size = 2'd2; b_uns = 1'b0; b_addr = addr; b_wdata = wd;
    #1;
  endtask

  task automatic store_a(input logic [1:0] sz, input logic [31:0] addr,
                         input logic [31:0] wd, input string name);
    drive_a(1'b1, 1'b1, sz, 1'b0, addr, wd);
    tests_run++;
    if (a_err !== 1'b0 || a_stall !== 1'b0 || a_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL %s: err=%b stall=%b rdata=%h, required err=0 stall=0 rdata=0",
               name, a_err, a_stall, a_rdata);
    end
  endtask

  task automatic load_a(input logic [1:0] sz, input logic u, input logic [31:0] addr,
                        input logic [31:0] exp, input string name);
    drive_a(1'b1, 1'b0, sz, u, addr, 32'h0);
    tests_run++;
    if (a_stall !== 1'b1 || a_rdata !== 32'h0 || a_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s accept: stall=%b rdata=%h err=%b, required stall=1 rdata=0 err=0",
               name, a_stall, a_rdata, a_err);
    end
    for (int i = 0; i < RL_A - 1; i++) begin
      @(negedge clk); #1;
      tests_run++;
      if (a_stall !== 1'b1 || a_rdata !== 32'h0) begin
        tests_failed++;
        $display("FAIL %s wait%0d: stall=%b rdata=%h, required stall=1 rdata=0",
                 name, i, a_stall, a_rdata);
      end
    end
    @(negedge clk); #1;
    tests_run++;
    if (a_stall !== 1'b0 || a_rdata !== exp || a_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s done: stall=%b rdata=%h err=%b, required stall=0 rdata=%h err=0",
               name, a_stall, a_rdata, a_err, exp);
    end
    drive_a(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    tests_run++;
    if (a_stall !== 1'b0 || a_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL %s after: stall=%b rdata=%h, required stall=0 rdata=0",
               name, a_stall, a_rdata);
    end
  endtask

  task automatic err_a(input logic w, input logic [1:0] sz, input logic [31:0] addr,
                       input logic [31:0] wd, input string name);
    drive_a(1'b1, w, sz, 1'b0, addr, wd);
    tests_run++;
    if (a_err !== 1'b1 || a_stall !== 1'b0 || a_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL %s: err=%b stall=%b rdata=%h, required err=1 stall=0 rdata=0",
               name, a_err, a_stall, a_rdata);
    end
    drive_a(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive_a(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    drive_b(1'b0, 1'b0, 32'h0, 32'h0);
    tests_run++;
    if (a_stall !== 1'b0 || a_err !== 1'b0 || a_rdata !== 32'h0 || a_mmio !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_hold: stall=%b err=%b rdata=%h mmio=%h, required all 0",
               a_stall, a_err, a_rdata, a_mmio);
    end
    drive_a(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    @(negedge clk); #1;
    tests_run++;
    if (a_stall !== 1'b0 || a_rdata !== 32'h0 || b_stall !== 1'b0 || b_mmio !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_release: a_stall=%b a_rdata=%h b_stall=%b b_mmio=%h, required 0",
               a_stall, a_rdata, b_stall, b_mmio);
    end
  endtask

  task automatic test_word;
    store_a(2'd2, 32'h10, 32'h8899_AABB, "sw_10");
    load_a(2'd2, 1'b0, 32'h10, 32'h8899_AABB, "lw_10");
  endtask

  task automatic test_byte;
    store_a(2'd0, 32'h13, 32'h0000_00F0, "sb_13");
    load_a(2'd0, 1'b0, 32'h13, 32'hFFFF_FFF0, "lb_13");
    load_a(2'd0, 1'b1, 32'h13, 32'h0000_00F0, "lbu_13");
    load_a(2'd2, 1'b0, 32'h10, 32'hF099_AABB, "lw_10_merged");
    load_a(2'd0, 1'b0, 32'h10, 32'hFFFF_FFBB, "lb_10");
  endtask

  task automatic test_half;
    store_a(2'd2, 32'h20, 32'h1234_5678, "sw_20");
    store_a(2'd1, 32'h22, 32'h0000_8001, "sh_22");
    load_a(2'd1, 1'b0, 32'h22, 32'hFFFF_8001, "lh_22");
    load_a(2'd1, 1'b1, 32'h22, 32'h0000_8001, "lhu_22");
    load_a(2'd1, 1'b0, 32'h20, 32'h0000_5678, "lh_20");
    err_a(1'b0, 2'd1, 32'h21, 32'h0, "lh_21_misaligned");
    err_a(1'b1, 2'd1, 32'h21, 32'h0000_BEEF, "sh_21_misaligned");
    load_a(2'd2, 1'b0, 32'h20, 32'h8001_5678, "lw_20_unchanged");
  endtask

  task automatic test_range;
    store_a(2'd2, 32'h0, 32'hCAFE_F00D, "sw_0");
    err_a(1'b1, 2'd2, 32'h1000, 32'hDEAD_BEEF, "sw_out_of_range");
    err_a(1'b1, 2'd3, 32'h0, 32'hDEAD_BEEF, "size3");
    err_a(1'b1, 2'd2, 32'h2, 32'hDEAD_BEEF, "sw_misaligned");
    load_a(2'd2, 1'b0, 32'h0, 32'hCAFE_F00D, "lw_0_no_alias");
  endtask

  task automatic test_mmio;
`ifdef DMEM_MMIO_EN
    store_a(2'd2, 32'hFFFF_FFF0, 32'h5, "mmio_sw");
    drive_a(1'b1, 1'b0, 2'd2, 1'b0, 32'hFFFF_FFF0, 32'h0);
    tests_run++;
    if (a_mmio !== 32'h5 || a_rdata !== 32'h5 || a_stall !== 1'b0 || a_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL mmio_lw: mmio=%h rdata=%h stall=%b err=%b, required 5 5 0 0",
               a_mmio, a_rdata, a_stall, a_err);
    end
    drive_a(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    err_a(1'b1, 2'd0, 32'hFFFF_FFF0, 32'h7, "mmio_sb");
    err_a(1'b0, 2'd2, 32'hFFFF_FF00, 32'h0, "mmio_other");
    tests_run++;
    if (a_mmio !== 32'h5) begin
      tests_failed++;
      $display("FAIL mmio_hold: mmio=%h, required 00000005", a_mmio);
    end
`else
    err_a(1'b1, 2'd2, 32'hFFFF_FFF0, 32'h5, "mmio_sw_unmapped");
    tests_run++;
    if (a_mmio !== 32'h0) begin
      tests_failed++;
      $display("FAIL mmio_off: mmio=%h, required 0", a_mmio);
    end
`endif
  endtask

  task automatic test_flush;
    drive_a(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    // drop valid and move the address during WAIT: captured copy must win
    drive_a(1'b0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    tests_run++;
    if (a_stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_wait: stall=%b, required 1", a_stall);
    end
    @(negedge clk); #1;
    tests_run++;
    if (a_stall !== 1'b0 || a_rdata !== 32'hF099_AABB) begin
      tests_failed++;
      $display("FAIL flush_done: stall=%b rdata=%h, required stall=0 rdata=f099aabb",
               a_stall, a_rdata);
    end
    @(negedge clk); #1;
    tests_run++;
    if (a_rdata !== 32'h0 || a_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_after: stall=%b rdata=%h, required 0 0", a_stall, a_rdata);
    end
  endtask

  task automatic test_reset_mid_load;
    drive_a(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    @(negedge clk); #1;
    rst = 1'b1;
    a_valid = 1'b0;
    #1;
    tests_run++;
    if (a_stall !== 1'b0 || a_rdata !== 32'h0 || a_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_load: stall=%b rdata=%h err=%b, required 0 0 0",
               a_stall, a_rdata, a_err);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (a_stall !== 1'b0 || a_rdata !== 32'h0) begin
        tests_failed++;
        $display("FAIL rst_release%0d: stall=%b rdata=%h, required 0 0", i, a_stall, a_rdata);
      end
      @(negedge clk); #1;
    end
    load_a(2'd2, 1'b0, 32'h10, 32'hF099_AABB, "lw_after_reset");
  endtask

  task automatic test_back_to_back;
    drive_b(1'b1, 1'b1, 32'h10, 32'h1111_2222);
    drive_b(1'b1, 1'b1, 32'h14, 32'h3333_4444);
    drive_b(1'b1, 1'b0, 32'h10, 32'h0);
    tests_run++;
    if (b_stall !== 1'b1 || b_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL b2b_stall0: stall=%b rdata=%h, required 1 0", b_stall, b_rdata);
    end
    @(negedge clk); #1;
    tests_run++;
    if (b_stall !== 1'b0 || b_rdata !== 32'h1111_2222) begin
      tests_failed++;
      $display("FAIL b2b_data0: stall=%b rdata=%h, required 0 11112222", b_stall, b_rdata);
    end
    drive_b(1'b1, 1'b0, 32'h14, 32'h0);
    tests_run++;
    if (b_stall !== 1'b1 || b_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL b2b_stall1: stall=%b rdata=%h, required 1 0", b_stall, b_rdata);
    end
    @(negedge clk); #1;
    tests_run++;
    if (b_stall !== 1'b0 || b_rdata !== 32'h3333_4444 || b_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_data1: stall=%b rdata=%h err=%b, required 0 33334444 0",
               b_stall, b_rdata, b_err);
    end
    drive_b(1'b0, 1'b0, 32'h0, 32'h0);
    tests_run++;
    if (b_rdata !== 32'h0 || b_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_idle: stall=%b rdata=%h, required 0 0", b_stall, b_rdata);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_write = 1'b0; a_size = 2'd0; a_uns = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_write = 1'b0; b_size = 2'd0; b_uns = 1'b0; b_addr = '0; b_wdata = '0;
    test_reset;
    test_word;
    test_byte;
    test_half;
    test_range;
    test_mmio;
    test_flush;
    test_reset_mid_load;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
